// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Pipeline stage link: valid / allowin handshake plus payload
//                bus. The upstream stage drives valid and bus through the
//                master modport; the downstream stage answers with allowin
//                through the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
    parameter int BUS_WD = 125
) ();
    logic              valid;
    logic              allowin;
    logic [BUS_WD-1:0] bus;

    modport master (
        output valid,
        output bus,
        input  allowin
    );

    modport slave (
        input  valid,
        input  bus,
        output allowin
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory pipeline stage. Registers the EX/MEM bus, buffers
//                synchronous data-SRAM read data while stalled, aligns and
//                extends load results, drives bypass/hazard outputs and the
//                MEM/WB bus with the valid/allowin handshake.
//  Options     : MS_LWLR_EN - when defined, lwl/lwr merge read data with
//                rt_value; when undefined those bits are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 125,
    parameter int MS_TO_WS_BUS_WD = 76
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    mem_stage_if.slave       es_ms,
    mem_stage_if.master      ms_ws,
    input  wire logic [31:0] data_sram_rdata,
    input  wire logic        ex_from_ws,
    output logic             ex_from_ms,
    output logic [31:0]      ms_forward,
    output logic [4:0]       ms_dest_h,
    output logic             ms_res_from_cp0_h
);

    // Outgoing payload before padding/truncation to MS_TO_WS_BUS_WD.
    localparam int C_PAYLOAD_WD = 85;

    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_es_bus;
    logic                       r_hold_valid;
    logic [31:0]                r_hold_data;

    // Handshake: the stage always completes in one cycle.
    logic w_ms_ready_go;
    assign w_ms_ready_go  = 1'b1;
    assign es_ms.allowin  = !r_ms_valid || (w_ms_ready_go && ms_ws.allowin);
    assign ms_ws.valid    = r_ms_valid && w_ms_ready_go && !ex_from_ws;

    // Stage valid: flush wins over a simultaneous accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid <= 1'b0;
        end else if (ex_from_ws) begin
            r_ms_valid <= 1'b0;
        end else if (es_ms.allowin) begin
            r_ms_valid <= es_ms.valid;
        end
    end

    // Payload register: loads only on an actual transfer from execute.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_es_bus <= '0;
        end else if (es_ms.valid && es_ms.allowin) begin
            r_es_bus <= es_ms.bus;
        end
    end

    // Read-data hold: capture the SRAM word on the first stalled edge, since
    // the SRAM output follows the next address execute issues.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (ex_from_ws || es_ms.allowin) begin
            r_hold_valid <= 1'b0;
        end else if (r_ms_valid && !ms_ws.allowin && !r_hold_valid) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= data_sram_rdata;
        end
    end

    // Field extraction from the registered execute payload.
    logic        w_eret, w_bd, w_mtc0_we, w_ex, w_res_from_cp0;
    logic [4:0]  w_cp0_addr, w_excode, w_dest;
    logic        w_ld_w, w_ld_h, w_ld_b, w_ld_sign, w_gr_we;
    logic [1:0]  w_addr_lo;
    logic [31:0] w_alu_result, w_pc;

    assign w_eret         = r_es_bus[124];
    assign w_bd           = r_es_bus[123];
    assign w_mtc0_we      = r_es_bus[122];
    assign w_cp0_addr     = r_es_bus[121:117];
    assign w_ex           = r_es_bus[116];
    assign w_excode       = r_es_bus[115:111];
    assign w_res_from_cp0 = r_es_bus[110];
    assign w_ld_w         = r_es_bus[75];
    assign w_ld_h         = r_es_bus[74];
    assign w_ld_b         = r_es_bus[73];
    assign w_ld_sign      = r_es_bus[72];
    assign w_addr_lo      = r_es_bus[71:70];
    assign w_gr_we        = r_es_bus[69];
    assign w_dest         = r_es_bus[68:64];
    assign w_alu_result   = r_es_bus[63:32];
    assign w_pc           = r_es_bus[31:0];

    // Load alignment.
    logic [31:0] w_rdata;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_half_ext, w_byte_ext;

    assign w_rdata    = r_hold_valid ? r_hold_data : data_sram_rdata;
    assign w_half     = w_addr_lo[1] ? w_rdata[31:16] : w_rdata[15:0];
    assign w_half_ext = {{16{w_ld_sign & w_half[15]}}, w_half};
    assign w_byte_ext = {{24{w_ld_sign & w_byte[7]}}, w_byte};

    // Byte lane select by the low address bits.
    always_comb begin
        w_byte = w_rdata[7:0];
        case (w_addr_lo)
            2'd0: w_byte = w_rdata[7:0];
            2'd1: w_byte = w_rdata[15:8];
            2'd2: w_byte = w_rdata[23:16];
            2'd3: w_byte = w_rdata[31:24];
            default: w_byte = w_rdata[7:0];
        endcase
    end

`ifdef MS_LWLR_EN
    logic        w_lwl, w_lwr;
    logic [31:0] w_rt_value;
    logic [31:0] w_lwl_val, w_lwr_val;

    assign w_lwl      = r_es_bus[109];
    assign w_lwr      = r_es_bus[108];
    assign w_rt_value = r_es_bus[107:76];

    // Unaligned-load merge: read bytes replace the upper (lwl) or lower (lwr)
    // part of rt according to the byte offset.
    always_comb begin
        w_lwl_val = w_rdata;
        w_lwr_val = w_rdata;
        case (w_addr_lo)
            2'd0: begin
                w_lwl_val = {w_rdata[7:0], w_rt_value[23:0]};
                w_lwr_val = w_rdata;
            end
            2'd1: begin
                w_lwl_val = {w_rdata[15:0], w_rt_value[15:0]};
                w_lwr_val = {w_rt_value[31:24], w_rdata[31:8]};
            end
            2'd2: begin
                w_lwl_val = {w_rdata[23:0], w_rt_value[7:0]};
                w_lwr_val = {w_rt_value[31:16], w_rdata[31:16]};
            end
            2'd3: begin
                w_lwl_val = w_rdata;
                w_lwr_val = {w_rt_value[31:8], w_rdata[31:24]};
            end
            default: begin
                w_lwl_val = w_rdata;
                w_lwr_val = w_rdata;
            end
        endcase
    end
`else
    logic w_unused_lwlr;
    assign w_unused_lwlr = ^r_es_bus[109:76];
`endif

    // Result mux: load value for any load, ALU result otherwise.
    logic [31:0] w_final_result;
    always_comb begin
        w_final_result = w_alu_result;
        if (w_ld_w) begin
            w_final_result = w_rdata;
        end else if (w_ld_h) begin
            w_final_result = w_half_ext;
        end else if (w_ld_b) begin
            w_final_result = w_byte_ext;
`ifdef MS_LWLR_EN
        end else if (w_lwl) begin
            w_final_result = w_lwl_val;
        end else if (w_lwr) begin
            w_final_result = w_lwr_val;
`endif
        end
    end

    // A faulting instruction still reaches writeback but must not write.
    logic                    w_ws_gr_we;
    logic [C_PAYLOAD_WD-1:0] w_payload;
    assign w_ws_gr_we = w_gr_we & ~w_ex;
    assign w_payload  = {w_eret, w_bd, w_mtc0_we, w_cp0_addr, w_ex, w_excode,
                         w_res_from_cp0, w_ws_gr_we, w_dest, w_final_result, w_pc};

    // Payload is LSB-aligned; a narrower bus drops the topmost CP0 fields.
    generate
        if (MS_TO_WS_BUS_WD >= C_PAYLOAD_WD) begin : g_pad
            assign ms_ws.bus = MS_TO_WS_BUS_WD'(w_payload);
        end else begin : g_trunc
            logic w_unused_hi;
            assign ms_ws.bus   = w_payload[MS_TO_WS_BUS_WD-1:0];
            assign w_unused_hi = ^w_payload[C_PAYLOAD_WD-1:MS_TO_WS_BUS_WD];
        end
    endgenerate

    assign ex_from_ms        = r_ms_valid & w_ex;
    assign ms_forward        = w_final_result;
    assign ms_dest_h         = (r_ms_valid & w_gr_we) ? w_dest : 5'd0;
    assign ms_res_from_cp0_h = r_ms_valid & w_res_from_cp0;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage: directed vector table,
//                hand-written stall/flush/reset sequences and randomized
//                transactions against a behavioural load-result model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int ES_WD = 125;
    localparam int WS_WD = 76;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] data_sram_rdata;
    logic        ex_from_ws;
    logic        ex_from_ms;
    logic [31:0] ms_forward;
    logic [4:0]  ms_dest_h;
    logic        ms_res_from_cp0_h;

    mem_stage_if #(.BUS_WD(ES_WD)) es_ms ();
    mem_stage_if #(.BUS_WD(WS_WD)) ms_ws ();

    always #5 clk = ~clk;

    mem_stage #(.ES_TO_MS_BUS_WD(ES_WD), .MS_TO_WS_BUS_WD(WS_WD)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_ms             (es_ms),
        .ms_ws             (ms_ws),
        .data_sram_rdata   (data_sram_rdata),
        .ex_from_ws        (ex_from_ws),
        .ex_from_ms        (ex_from_ms),
        .ms_forward        (ms_forward),
        .ms_dest_h         (ms_dest_h),
        .ms_res_from_cp0_h (ms_res_from_cp0_h)
    );

    typedef struct {
        logic        eret, bd, mtc0_we, ex, res_cp0;
        logic [4:0]  cp0_addr, excode, dest;
        logic        lwl, lwr, ld_w, ld_h, ld_b, sign, gr_we;
        logic [1:0]  a;
        logic [31:0] rt, alu, pc;
    } txn_t;

    typedef struct {
        string       name;
        logic        w, h, b, s, l, r;
        logic [1:0]  a;
        logic [31:0] rd, rt, alu, exp;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    function automatic logic [ES_WD-1:0] bus_of(input txn_t t);
        logic [ES_WD-1:0] b;
        b          = '0;
        b[124]     = t.eret;    b[123]     = t.bd;    b[122]     = t.mtc0_we;
        b[121:117] = t.cp0_addr; b[116]    = t.ex;    b[115:111] = t.excode;
        b[110]     = t.res_cp0; b[109]     = t.lwl;   b[108]     = t.lwr;
        b[107:76]  = t.rt;      b[75]      = t.ld_w;  b[74]      = t.ld_h;
        b[73]      = t.ld_b;    b[72]      = t.sign;  b[71:70]   = t.a;
        b[69]      = t.gr_we;   b[68:64]   = t.dest;  b[63:32]   = t.alu;
        b[31:0]    = t.pc;
        return b;
    endfunction

    // Reference: load value computed arithmetically from the byte offset.
    function automatic logic [31:0] model_result(input txn_t t, input logic [31:0] rd);
        logic [31:0] v;
        int          k;
        if (t.ld_w) return rd;
        if (t.ld_h) begin
            k = (int'(t.a) / 2) * 16;
            v = (rd >> k) & 32'h0000_FFFF;
            if (t.sign && v >= 32'h0000_8000) v = v - 32'h0001_0000;
            return v;
        end
        if (t.ld_b) begin
            k = int'(t.a) * 8;
            v = (rd >> k) & 32'h0000_00FF;
            if (t.sign && v >= 32'h0000_0080) v = v - 32'h0000_0100;
            return v;
        end
`ifdef MS_LWLR_EN
        if (t.lwl) begin
            k = (3 - int'(t.a)) * 8;
            if (k == 0) return rd;
            return (rd << k) | (t.rt & ((32'h1 << k) - 32'h1));
        end
        if (t.lwr) begin
            k = int'(t.a) * 8;
            if (k == 0) return rd;
            return (rd >> k) | (t.rt & ~(32'hFFFF_FFFF >> k));
        end
`endif
        return t.alu;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   kind;
        t.eret = 1'($urandom); t.bd = 1'($urandom); t.mtc0_we = 1'($urandom);
        t.cp0_addr = 5'($urandom); t.ex = ($urandom_range(0, 7) == 0);
        t.excode = 5'($urandom); t.res_cp0 = 1'($urandom);
        t.rt = $urandom; t.alu = $urandom; t.pc = $urandom;
        t.a = 2'($urandom); t.sign = 1'($urandom);
        t.gr_we = 1'($urandom); t.dest = 5'($urandom);
        kind = $urandom_range(0, 5);
        t.ld_w = (kind == 1); t.ld_h = (kind == 2); t.ld_b = (kind == 3);
        t.lwl  = (kind == 4); t.lwr  = (kind == 5);
        return t;
    endfunction

    function automatic txn_t plain_txn();
        txn_t t;
        t = rand_txn();
        t.ex = 1'b0; t.lwl = 1'b0; t.lwr = 1'b0;
        t.ld_w = 1'b0; t.ld_h = 1'b0; t.ld_b = 1'b0;
        return t;
    endfunction

    task automatic check_outputs(input string tag, input txn_t t, input logic [31:0] exp);
        check({tag, ".ws_valid"}, 32'(ms_ws.valid), 32'd1);
        check({tag, ".final"},    ms_ws.bus[63:32], exp);
        check({tag, ".forward"},  ms_forward, exp);
        check({tag, ".pc"},       ms_ws.bus[31:0], t.pc);
        check({tag, ".wb_we"},    32'(ms_ws.bus[69]), 32'(t.gr_we & ~t.ex));
        check({tag, ".wb_dest"},  32'(ms_ws.bus[68:64]), 32'(t.dest));
        check({tag, ".excode"},   32'(ms_ws.bus[75:71]), 32'(t.excode));
        check({tag, ".dest_h"},   32'(ms_dest_h), t.gr_we ? 32'(t.dest) : 32'd0);
        check({tag, ".ex_ms"},    32'(ex_from_ms), 32'(t.ex));
        check({tag, ".cp0_h"},    32'(ms_res_from_cp0_h), 32'(t.res_cp0));
    endtask

    // One instruction: accept, present rd the next cycle, stall for `stall`
    // cycles while the SRAM output wanders to `junk`, then release.
    task automatic run_txn(input string tag, input txn_t t, input logic [31:0] rd,
                           input int stall, input logic [31:0] junk, input logic [31:0] exp);
        @(negedge clk);
        es_ms.valid   = 1'b1;
        es_ms.bus     = bus_of(t);
        ms_ws.allowin = 1'b1;
        #1 check({tag, ".allowin"}, 32'(es_ms.allowin), 32'd1);
        @(posedge clk);
        #1;
        es_ms.valid     = 1'b0;
        ms_ws.allowin   = (stall == 0);
        data_sram_rdata = rd;
        #1 check_outputs(tag, t, exp);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            data_sram_rdata = junk;
            if (i == stall - 1) ms_ws.allowin = 1'b1;
            #1 check_outputs({tag, ".stall"}, t, exp);
        end
    endtask

    vec_t vecs[9];
    txn_t t;
    txn_t t2;
    logic [31:0] rd;

    function automatic vec_t mkv(input string n, input logic w, h, b, s, l, r,
                                 input logic [1:0] a, input logic [31:0] rd_i, rt, alu, exp);
        vec_t v;
        v.name = n; v.w = w; v.h = h; v.b = b; v.s = s; v.l = l; v.r = r;
        v.a = a; v.rd = rd_i; v.rt = rt; v.alu = alu; v.exp = exp;
        return v;
    endfunction

    initial begin
        vecs[0] = mkv("lb_a3",  0, 0, 1, 1, 0, 0, 2'd3, 32'h80FF_1234, 32'h0, 32'h0BAD_0001, 32'hFFFF_FF80);
        vecs[1] = mkv("lbu_a3", 0, 0, 1, 0, 0, 0, 2'd3, 32'h80FF_1234, 32'h0, 32'h0BAD_0002, 32'h0000_0080);
        vecs[2] = mkv("lh_a2",  0, 1, 0, 1, 0, 0, 2'd2, 32'h8001_0000, 32'h0, 32'h0BAD_0003, 32'hFFFF_8001);
        vecs[3] = mkv("lw",     1, 0, 0, 0, 0, 0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0BAD_0004, 32'hDEAD_BEEF);
        vecs[4] = mkv("lhu_a0", 0, 1, 0, 0, 0, 0, 2'd0, 32'h1234_F00D, 32'h0, 32'h0BAD_0005, 32'h0000_F00D);
        vecs[5] = mkv("lb_a1",  0, 0, 1, 1, 0, 0, 2'd1, 32'h1234_7F56, 32'h0, 32'h0BAD_0006, 32'h0000_007F);
        vecs[6] = mkv("alu",    0, 0, 0, 0, 0, 0, 2'd2, 32'h5555_AAAA, 32'h0, 32'hCAFE_0001, 32'hCAFE_0001);
`ifdef MS_LWLR_EN
        vecs[7] = mkv("lwl_a1", 0, 0, 0, 0, 1, 0, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h0BAD_0008, 32'hCCDD_3344);
        vecs[8] = mkv("lwr_a1", 0, 0, 0, 0, 0, 1, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h0BAD_0009, 32'h11AA_BBCC);
`else
        vecs[7] = mkv("lwl_a1", 0, 0, 0, 0, 1, 0, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h0BAD_0008, 32'h0BAD_0008);
        vecs[8] = mkv("lwr_a1", 0, 0, 0, 0, 0, 1, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h0BAD_0009, 32'h0BAD_0009);
`endif

        resetn          = 1'b0;
        es_ms.valid     = 1'b0;
        es_ms.bus       = '0;
        ms_ws.allowin   = 1'b1;
        ex_from_ws      = 1'b0;
        data_sram_rdata = 32'h0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst.ws_valid", 32'(ms_ws.valid), 32'd0);
        check("rst.bus_lo",   ms_ws.bus[31:0], 32'd0);
        check("rst.bus_hi",   32'(ms_ws.bus[WS_WD-1:32]), 32'd0);
        check("rst.forward",  ms_forward, 32'd0);
        check("rst.dest_h",   32'(ms_dest_h), 32'd0);
        check("rst.ex_ms",    32'(ex_from_ms), 32'd0);
        check("rst.cp0_h",    32'(ms_res_from_cp0_h), 32'd0);
        check("rst.allowin",  32'(es_ms.allowin), 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        // Directed load-alignment vectors.
        foreach (vecs[i]) begin
            t = plain_txn();
            t.ld_w = vecs[i].w; t.ld_h = vecs[i].h; t.ld_b = vecs[i].b;
            t.sign = vecs[i].s; t.lwl = vecs[i].l; t.lwr = vecs[i].r;
            t.a = vecs[i].a; t.rt = vecs[i].rt; t.alu = vecs[i].alu;
            run_txn(vecs[i].name, t, vecs[i].rd, 0, 32'h0, vecs[i].exp);
        end

        // Stall three cycles: the first-cycle SRAM word must be kept.
        t = plain_txn();
        t.ld_w = 1'b1;
        run_txn("hold", t, 32'h1111_1111, 3, 32'h2222_2222, 32'h1111_1111);
        // Accept while the held instruction leaves: new word used fresh.
        t = plain_txn();
        t.ld_w = 1'b1;
        run_txn("after_hold", t, 32'h3333_3333, 0, 32'h0, 32'h3333_3333);

        // Exception in this stage, then flush coincident with a new offer.
        t = plain_txn();
        t.ld_w = 1'b1; t.ex = 1'b1; t.excode = 5'h04; t.gr_we = 1'b1; t.dest = 5'd7;
        run_txn("exc", t, 32'h0F0F_0F0F, 0, 32'h0, 32'h0F0F_0F0F);
        t2 = plain_txn();
        t2.gr_we = 1'b1; t2.dest = 5'd9;
        @(negedge clk);
        ex_from_ws  = 1'b1;
        es_ms.valid = 1'b1;
        es_ms.bus   = bus_of(t2);
        #1 check("flush.ws_valid_now", 32'(ms_ws.valid), 32'd0);
        @(posedge clk);
        #1;
        ex_from_ws  = 1'b0;
        es_ms.valid = 1'b0;
        #1;
        check("flush.ws_valid", 32'(ms_ws.valid), 32'd0);
        check("flush.dest_h",   32'(ms_dest_h), 32'd0);
        check("flush.ex_ms",    32'(ex_from_ms), 32'd0);

        // Asynchronous reset in the middle of a stall with data held.
        t = plain_txn();
        t.ld_w = 1'b1; t.gr_we = 1'b1; t.dest = 5'd3;
        @(negedge clk);
        es_ms.valid   = 1'b1;
        es_ms.bus     = bus_of(t);
        ms_ws.allowin = 1'b1;
        @(posedge clk);
        #1;
        es_ms.valid     = 1'b0;
        ms_ws.allowin   = 1'b0;
        data_sram_rdata = 32'h4444_4444;
        @(posedge clk);
        #1;
        data_sram_rdata = 32'h5555_5555;
        #1 check("rst_mid.held", ms_forward, 32'h4444_4444);
        resetn = 1'b0;
        #1;
        check("rst_mid.ws_valid", 32'(ms_ws.valid), 32'd0);
        check("rst_mid.dest_h",   32'(ms_dest_h), 32'd0);
        check("rst_mid.forward",  ms_forward, 32'd0);
        @(negedge clk);
        resetn        = 1'b1;
        ms_ws.allowin = 1'b1;
        t = plain_txn();
        t.ld_w = 1'b1;
        run_txn("post_rst", t, 32'h6666_6666, 0, 32'h0, 32'h6666_6666);

        // Randomized traffic with random stalls against the reference model.
        for (int n = 0; n < 150; n++) begin
            int st;
            t  = rand_txn();
            rd = $urandom;
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_txn("rand", t, rd, st, $urandom, model_result(t, rd));
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
